// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel synchroniser, debounce filter and edge
// detector with mode-qualified pulses, sticky event flags and a summary irq.
//
// Ports:
//   clk     in   1           clock
//   reset   in   1           synchronous, active-high reset
//   in      in   CHANNELS    raw inputs, one bit per channel
//   mode    in   2*CHANNELS  per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clear   in   CHANNELS    per-channel sticky clear (level-sensitive)
//   level   out  CHANNELS    filtered level
//   pulse   out  CHANNELS    one-cycle edge pulse qualified by mode
//   rise    out  CHANNELS    one-cycle pulse on any accepted rising edge
//   fall    out  CHANNELS    one-cycle pulse on any accepted falling edge
//   sticky  out  CHANNELS    latched qualified events
//   irq     out  1           registered OR of sticky
module edge_detect_multi #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   rise,
  output logic [CHANNELS-1:0]   fall,
  output logic [CHANNELS-1:0]   sticky,
  output logic                  irq
);

  localparam int unsigned CNT_W =
    (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] level_nxt;

  // Input synchroniser (bypassed when inputs are already synchronous)
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = in;
    end else begin : g_sync
      logic [CHANNELS-1:0] chain [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < SYNC_STAGES; k++) chain[k] <= '0;
        end else begin
          chain[0] <= in;
          for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
        end
      end

      assign s = chain[SYNC_STAGES-1];
    end
  endgenerate

  // Debounce filter: a new level is accepted once it has persisted
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nofilt
      assign level_nxt = s;
    end else begin : g_filt
      localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q [CHANNELS];
      logic [CNT_W-1:0] cnt_d [CHANNELS];

      always_comb begin
        level_nxt = level;
        for (int i = 0; i < CHANNELS; i++) begin
          cnt_d[i] = '0;
          if (s[i] != level[i]) begin
            if (cnt_q[i] == LAST) begin
              level_nxt[i] = ~level[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else begin
          for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
        end
      end
    end
  endgenerate

  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;
  logic [CHANNELS-1:0] pulse_d;
  logic [CHANNELS-1:0] sticky_d;
  logic                irq_d;

  // Edge detection, mode qualification and sticky flags (set beats clear)
  always_comb begin
    rise_d   = level_nxt & ~level;
    fall_d   = ~level_nxt & level;
    pulse_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pulse_d[i] = (rise_d[i] & mode[2*i]) | (fall_d[i] & mode[2*i+1]);
    end
    sticky_d = pulse | (sticky & ~clear);
    irq_d    = |sticky;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      level  <= '0;
      rise   <= '0;
      fall   <= '0;
      pulse  <= '0;
      sticky <= '0;
      irq    <= 1'b0;
    end else begin
      level  <= level_nxt;
      rise   <= rise_d;
      fall   <= fall_d;
      pulse  <= pulse_d;
      sticky <= sticky_d;
      irq    <= irq_d;
    end
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi: default configuration (4 ch, 2 sync
// stages, debounce 3) plus a 1-channel instance with no sync and no filter.
module tb_edge_detect_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in;
  logic [7:0] mode;
  logic [3:0] clear;
  logic [3:0] level, pulse, rise, fall, sticky;
  logic       irq;

  logic       in0;
  logic [1:0] mode0;
  logic       clear0;
  logic       level0, pulse0, rise0, fall0, sticky0;
  logic       irq0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  edge_detect_multi u_dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in),
    .mode   (mode),
    .clear  (clear),
    .level  (level),
    .pulse  (pulse),
    .rise   (rise),
    .fall   (fall),
    .sticky (sticky),
    .irq    (irq)
  );

  edge_detect_multi #(
    .CHANNELS        (1),
    .SYNC_STAGES     (0),
    .DEBOUNCE_CYCLES (0)
  ) u_dut0 (
    .clk    (clk),
    .reset  (reset),
    .in     (in0),
    .mode   (mode0),
    .clear  (clear0),
    .level  (level0),
    .pulse  (pulse0),
    .rise   (rise0),
    .fall   (fall0),
    .sticky (sticky0),
    .irq    (irq0)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] in_v);
    reset = 1'b1;
    in    = in_v;
    clear = 4'b0000;
    tick(2);
    reset = 1'b0;
  endtask

  int pcnt [4];
  int rcnt [4];
  int fcnt [4];

  initial begin
    reset  = 1'b1;
    in     = 4'b0000;
    mode   = 8'b01_01_01_01;
    clear  = 4'b0000;
    in0    = 1'b0;
    mode0  = 2'b11;
    clear0 = 1'b0;

    // 1: reset state and basic latency
    do_reset(4'b0000);
    chk("rst_level",  32'(level),  32'h0);
    chk("rst_pulse",  32'(pulse),  32'h0);
    chk("rst_rise",   32'(rise),   32'h0);
    chk("rst_fall",   32'(fall),   32'h0);
    chk("rst_sticky", 32'(sticky), 32'h0);
    chk("rst_irq",    32'(irq),    32'h0);
    in = 4'b0001;
    tick(4);
    chk("t1_level_early", 32'(level), 32'h0);
    chk("t1_pulse_early", 32'(pulse), 32'h0);
    tick(1);
    chk("t1_level",  32'(level),  32'h1);
    chk("t1_rise",   32'(rise),   32'h1);
    chk("t1_pulse",  32'(pulse),  32'h1);
    chk("t1_sticky_early", 32'(sticky), 32'h0);
    tick(1);
    chk("t1_pulse_gone", 32'(pulse),  32'h0);
    chk("t1_rise_gone",  32'(rise),   32'h0);
    chk("t1_sticky",     32'(sticky), 32'h1);
    chk("t1_irq_early",  32'(irq),    32'h0);
    tick(1);
    chk("t1_irq", 32'(irq), 32'h1);
    clear = 4'b0001;
    tick(1);
    clear = 4'b0000;
    chk("t1_sticky_clr", 32'(sticky), 32'h0);
    tick(1);
    chk("t1_irq_clr", 32'(irq), 32'h0);

    // 2: glitch rejection on ch1, then an accepted rise
    mode = 8'b00_00_11_00;
    do_reset(4'b0000);
    in = 4'b0010;
    tick(2);
    in = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("t2_glitch_level", 32'(level), 32'h0);
      chk("t2_glitch_edges", 32'(rise | fall | pulse), 32'h0);
    end
    chk("t2_glitch_sticky", 32'(sticky), 32'h0);
    in = 4'b0010;
    tick(4);
    chk("t2_level_early", 32'(level), 32'h0);
    tick(1);
    chk("t2_level", 32'(level), 32'h2);
    chk("t2_rise",  32'(rise),  32'h2);
    chk("t2_pulse", 32'(pulse), 32'h2);
    tick(1);
    chk("t2_rise_single", 32'(rise),   32'h0);
    chk("t2_sticky",      32'(sticky), 32'h2);

    // 3: mode coverage, ch0..ch3 = off, rise, fall, both
    mode = 8'b11_10_01_00;
    do_reset(4'b0000);
    for (int c = 0; c < 4; c++) begin
      pcnt[c] = 0;
      rcnt[c] = 0;
      fcnt[c] = 0;
    end
    in = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) in = 4'b0000;
      tick(1);
      for (int c = 0; c < 4; c++) begin
        pcnt[c] += int'(pulse[c]);
        rcnt[c] += int'(rise[c]);
        fcnt[c] += int'(fall[c]);
      end
    end
    chk("t3_pulse_ch0", 32'(pcnt[0]), 32'd0);
    chk("t3_pulse_ch1", 32'(pcnt[1]), 32'd1);
    chk("t3_pulse_ch2", 32'(pcnt[2]), 32'd1);
    chk("t3_pulse_ch3", 32'(pcnt[3]), 32'd2);
    for (int c = 0; c < 4; c++) begin
      chk("t3_rise_cnt", 32'(rcnt[c]), 32'd1);
      chk("t3_fall_cnt", 32'(fcnt[c]), 32'd1);
    end
    chk("t3_sticky", 32'(sticky), 32'hE);
    chk("t3_irq",    32'(irq),    32'h1);
    chk("t3_level",  32'(level),  32'h0);

    // 4: sticky set wins over a held clear
    mode = 8'b00_01_00_00;
    do_reset(4'b0000);
    clear = 4'b0100;
    in    = 4'b0100;
    tick(5);
    chk("t4_pulse",        32'(pulse),  32'h4);
    chk("t4_sticky_pre",   32'(sticky), 32'h0);
    tick(1);
    chk("t4_sticky_set",   32'(sticky), 32'h4);
    tick(1);
    chk("t4_sticky_clr",   32'(sticky), 32'h0);
    chk("t4_irq",          32'(irq),    32'h1);
    tick(1);
    chk("t4_irq_clr",      32'(irq),    32'h0);
    clear = 4'b0000;

    // 5: input held high through reset; reset aborting a debounce count
    mode  = 8'b01_00_00_01;
    reset = 1'b1;
    in    = 4'b0001;
    tick(3);
    chk("t5_in_reset_level", 32'(level), 32'h0);
    reset = 1'b0;
    tick(4);
    chk("t5_level_early", 32'(level), 32'h0);
    tick(1);
    chk("t5_level", 32'(level), 32'h1);
    chk("t5_rise",  32'(rise),  32'h1);
    chk("t5_pulse", 32'(pulse), 32'h1);
    tick(1);
    chk("t5_rise_once", 32'(rise), 32'h0);
    do_reset(4'b0000);
    in = 4'b1000;
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("t5_abort_level", 32'(level), 32'h0);
    chk("t5_abort_pulse", 32'(pulse), 32'h0);
    reset = 1'b0;
    tick(4);
    chk("t5_restart_early", 32'(level), 32'h0);
    tick(1);
    chk("t5_restart_level", 32'(level), 32'h8);
    chk("t5_restart_pulse", 32'(pulse), 32'h8);

    // 6: no sync, no filter, 1 channel: pulse every cycle
    do_reset(4'b0000);
    chk("t6_rst_level", 32'(level0), 32'h0);
    for (int k = 0; k < 6; k++) begin
      in0 = ~in0;
      tick(1);
      chk("t6_level", 32'(level0), 32'(in0));
      chk("t6_pulse", 32'(pulse0), 32'h1);
      chk("t6_edge",  32'({rise0, fall0}), in0 ? 32'h2 : 32'h1);
    end
    tick(1);
    chk("t6_pulse_stop", 32'(pulse0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Parametrised, multi-channel successor to the single-bit falling-edge detector.
- Per channel it provides:
  - an input synchroniser;
  - a glitch/debounce filter;
  - mode-selectable rise, fall or both-edge detection, giving one-cycle pulses;
  - sticky event flags with software clear.
- Sits between raw camera/GPIO strobes and the vision pipeline control logic; `irq` summarises pending events.

Parameters:
- CHANNELS, 4, number of independent input channels (≥1).
- SYNC_STAGES, 2, synchroniser flops per channel (0 = input used directly, already synchronous).
- DEBOUNCE_CYCLES, 3, consecutive cycles a new level must persist before acceptance (0 = filter disabled).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1) (min 1), debounce counter width (derived; not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in  in  CHANNELS  raw inputs, one bit per channel
- mode  in  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- clear  in  CHANNELS  per-channel sticky clear, level-sensitive
- level  out  CHANNELS  filtered (debounced) level
- pulse  out  CHANNELS  one-cycle edge pulse, qualified by mode
- rise  out  CHANNELS  one-cycle pulse on any accepted rising edge, unqualified by mode
- fall  out  CHANNELS  one-cycle pulse on any accepted falling edge, unqualified by mode
- sticky  out  CHANNELS  latched qualified events
- irq  out  1  OR-reduction of sticky, registered

Behaviour:
- Clocking and reset:
  - Single clock domain; every register updates on posedge clk.
  - reset (synchronous, active-high) clears sync chain, debounce counters, level, pulse, rise, fall, sticky and irq to 0.
- Reset mid-operation: aborts any in-progress debounce count. The counter restarts from 0 after reset deasserts.
- Filtered level after reset is 0. A channel whose input is held high through reset therefore produces one accepted rising edge after the normal latency. This is intended and must be tested.
- Synchroniser: s[i] = output of SYNC_STAGES-deep flop chain. With SYNC_STAGES=0, s[i] = in[i] combinationally.
- Debounce, per channel (DEBOUNCE_CYCLES = D > 0):
  - s == level: counter cleared to 0.
  - s != level and counter < D-1: counter increments.
  - s != level and counter == D-1: level toggles on this edge, counter cleared to 0.
  - Any return of s to level before acceptance clears the counter. Glitches shorter than D cycles are discarded with no output activity.
- D = 0: level <= s every cycle (single register stage).
- Edge generation (all registered, asserted for exactly one cycle):
  - rise/fall: asserted in the same cycle the new level value first appears on the output. rise = level changed 0→1; fall = level changed 1→0.
  - pulse[i] = (rise[i] & mode[2i]) | (fall[i] & mode[2i+1]), with mode sampled on the clock edge at which level toggles.
  - mode 00 suppresses pulse/sticky only; level, rise and fall still operate.
  - A mode change takes effect on the next accepted edge. There is no retroactive effect and no pulse is generated by a mode change itself.
- Latency: an input stable from edge k produces the level/pulse change visible after edge k + SYNC_STAGES + max(D,1) - 1.
  - Defaults: 5 edges from input change to pulse.
- Back-to-back edges:
  - Minimum spacing between accepted edges on one channel is D cycles (1 cycle when D=0).
  - Consecutive pulses may then be adjacent only when D ≤ 1.
- Sticky:
  - Set by a qualified event: sticky[i] <= 1 on the cycle pulse[i] is asserted.
  - Clear: sticky[i] <= 0 when clear[i]=1.
  - Simultaneous set and clear: set wins, so no event is lost.
  - clear held high continuously is overridden by each new event for that cycle.
- irq: registered OR of sticky, one cycle behind sticky.
- Channels are fully independent; no cross-channel interaction apart from irq.

Test Plan:
1. Reset with in=4'b0000, all modes 01 → all outputs 0; then in[0] 0→1 held → level[0], rise[0] and pulse[0] assert exactly 5 edges later, sticky[0] next, irq one cycle after sticky.
2. Glitch rejection: in[1] high for 2 cycles then low (D=3, mode 11) → no change on level, rise, fall, pulse or sticky. Then high for 3 cycles → level[1]=1 with a single rise pulse.
3. Mode coverage: ch0..ch3 modes 00, 01, 10, 11; each input toggles 0→1→0 with 10-cycle holds.
   - pulse counts: 0, 1, 1 and 2 respectively.
   - rise = 1 and fall = 1 on every channel.
   - sticky set only on ch1–3.
4. Sticky clear collision: clear[2]=1 held and asserted on the same edge as pulse[2] → sticky[2] stays 1 that cycle and clears on the following cycle (clear still high, no new event).
5. Input held high through reset, then reset deasserts → level=1 and one rise pulse 5 edges later. Reset asserted mid-debounce (counter=2) → no pulse, counter restarts from 0.
6. Parameter sweep: SYNC_STAGES=0, DEBOUNCE_CYCLES=0, CHANNELS=1 → in toggles every cycle, pulse (mode 11) asserted every cycle, one edge after input.
